// File: rtl/spi_xip_apb_bridge_if.sv
// APB slave bundle for the SPI XIP bridge.
// Carries paddr/psel/penable/pwrite/pprot/pwdata/pstrb in, pready/prdata/pslverr out.
interface spi_xip_apb_bridge_if;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic        in_pwrite;
  logic [2:0]  in_pprot;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;

  modport slave (
    input  in_paddr, in_psel, in_penable, in_pwrite,
    input  in_pprot, in_pwdata, in_pstrb,
    output in_pready, in_prdata, in_pslverr
  );

  modport master (
    output in_paddr, in_psel, in_penable, in_pwrite,
    output in_pprot, in_pwdata, in_pstrb,
    input  in_pready, in_prdata, in_pslverr
  );
endinterface

// File: rtl/spi_xip_apb_bridge.sv
// APB read-only bridge to a SPI NOR flash (03h read, mode 0, one word).
// Ports: clock, reset (async active-low), apb (slave modport),
//   spi_sck, spi_ss[SS_NUM] (active-low), spi_mosi, spi_miso.
// Optional macro SPI_XIP_LINE_BUF_EN adds a one-word read buffer.
module spi_xip_apb_bridge #(
  parameter logic [31:0] FLASH_BASE      = 32'h30000000,
  parameter int          FLASH_SIZE_LOG2 = 24,
  parameter int          SS_NUM          = 8,
  parameter int          SS_IDX          = 0,
  parameter int          CLK_DIV         = 1
) (
  input  logic              clock,
  input  logic              reset,
  spi_xip_apb_bridge_if.slave apb,
  output logic              spi_sck,
  output logic [SS_NUM-1:0] spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SHIFT_OUT = 2'd1;
  localparam logic [1:0] S_SHIFT_IN  = 2'd2;
  localparam logic [1:0] S_RESP      = 2'd3;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam int         WA       = FLASH_SIZE_LOG2 - 2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        tail_q, tail_d;
  logic        err_q, err_d;
  logic [31:0] sreg_q, sreg_d;
  logic [31:0] prdata_q, prdata_d;

  logic [32:0] off;
  logic        in_win;
  logic [21:0] waddr;
  logic        accept;
  logic        tick;
  logic [31:0] frame;
  logic        unused_apb;

  assign unused_apb = ^{apb.in_pprot, apb.in_pwdata, apb.in_pstrb};

`ifdef SPI_XIP_LINE_BUF_EN
  logic        buf_vld_q, buf_vld_d;
  logic [21:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [21:0] waddr_q, waddr_d;
  logic        hit;
`endif

  always_comb begin
    off    = {1'b0, apb.in_paddr} - {1'b0, FLASH_BASE};
    in_win = !off[32] && (off[31:FLASH_SIZE_LOG2] == '0);
    waddr  = '0;
    waddr[WA-1:0] = apb.in_paddr[FLASH_SIZE_LOG2-1:2];
    accept = apb.in_psel & apb.in_penable;
    tick   = (div_q == DIV_LAST);
    frame  = {8'h03, waddr, 2'b00};
  end

`ifdef SPI_XIP_LINE_BUF_EN
  assign hit = buf_vld_q && (buf_addr_q == waddr);
`endif

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    tail_d   = tail_q;
    err_d    = err_q;
    sreg_d   = sreg_q;
    prdata_d = prdata_q;
`ifdef SPI_XIP_LINE_BUF_EN
    buf_vld_d  = buf_vld_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    waddr_d    = waddr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (apb.in_pwrite || !in_win) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
`ifdef SPI_XIP_LINE_BUF_EN
          else if (hit) begin
            state_d  = S_RESP;
            err_d    = 1'b0;
            prdata_d = buf_data_q;
            waddr_d  = waddr;
          end
`endif
          else begin
            state_d = S_SHIFT_OUT;
            err_d   = 1'b0;
            sreg_d  = frame;
            mosi_d  = frame[31];
            div_d   = '0;
            bit_d   = '0;
            sck_d   = 1'b0;
            tail_d  = 1'b0;
`ifdef SPI_XIP_LINE_BUF_EN
            waddr_d = waddr;
`endif
          end
        end
      end
      S_SHIFT_OUT: begin
        if (tick) begin
          div_d = '0;
          sck_d = !sck_q;
          // falling edge: present next bit while sck is low
          if (sck_q) begin
            sreg_d = {sreg_q[30:0], 1'b0};
            mosi_d = sreg_q[30];
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              state_d = S_SHIFT_IN;
              mosi_d  = 1'b0;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_SHIFT_IN: begin
        // one low hold cycle after the last fall closes the frame
        if (tail_q) begin
          state_d  = S_RESP;
          tail_d   = 1'b0;
          prdata_d = {sreg_q[7:0], sreg_q[15:8],
                      sreg_q[23:16], sreg_q[31:24]};
        end else if (tick) begin
          div_d = '0;
          sck_d = !sck_q;
          if (!sck_q) begin
            sreg_d = {sreg_q[30:0], spi_miso};
          end else begin
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) tail_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
`ifdef SPI_XIP_LINE_BUF_EN
        if (!err_q) begin
          buf_vld_d  = 1'b1;
          buf_addr_d = waddr_q;
          buf_data_d = prdata_q;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      tail_q   <= 1'b0;
      err_q    <= 1'b0;
      sreg_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      tail_q   <= tail_d;
      err_q    <= err_d;
      sreg_q   <= sreg_d;
      prdata_q <= prdata_d;
    end
  end

`ifdef SPI_XIP_LINE_BUF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_vld_q  <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      waddr_q    <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      waddr_q    <= waddr_d;
    end
  end
`endif

  always_comb begin
    spi_ss         = '1;
    spi_ss[SS_IDX] = !((state_q == S_SHIFT_OUT) ||
                       (state_q == S_SHIFT_IN));
  end

  assign spi_sck        = sck_q;
  assign spi_mosi       = mosi_q;
  assign apb.in_pready  = (state_q == S_RESP);
  assign apb.in_pslverr = (state_q == S_RESP) && err_q;
  assign apb.in_prdata  = prdata_q;

endmodule

// File: tb/tb_spi_xip_apb_bridge.sv
// Directed bench for spi_xip_apb_bridge: two instances, CLK_DIV 1 and 3.
// Flash model answers on miso; monitors capture mosi frame and sck timing.
module tb_spi_xip_apb_bridge;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [31:0] paddr[2];
  logic        psel[2];
  logic        penable[2];
  logic        pwrite[2];
  logic        pready[2];
  logic        pslverr[2];
  logic [31:0] prdata[2];
  logic        sck[2];
  logic        mosi[2];
  logic        miso[2];
  logic [7:0]  ss[2];

  logic [31:0] rxw[2];
  logic [6:0]  fcnt[2] = '{7'd0, 7'd0};
  logic [31:0] mosi_cap[2];
  int          rises_lo[2] = '{0, 0};
  int          rises_hi[2] = '{0, 0};
  int          bad_phase[2] = '{0, 0};

  int checks = 0;
  int failures = 0;

  spi_xip_apb_bridge_if if0();
  spi_xip_apb_bridge_if if1();

  assign if0.in_paddr   = paddr[0];
  assign if0.in_psel    = psel[0];
  assign if0.in_penable = penable[0];
  assign if0.in_pwrite  = pwrite[0];
  assign if0.in_pprot   = 3'b010;
  assign if0.in_pwdata  = 32'hCAFEF00D;
  assign if0.in_pstrb   = 4'hF;
  assign pready[0]      = if0.in_pready;
  assign pslverr[0]     = if0.in_pslverr;
  assign prdata[0]      = if0.in_prdata;

  assign if1.in_paddr   = paddr[1];
  assign if1.in_psel    = psel[1];
  assign if1.in_penable = penable[1];
  assign if1.in_pwrite  = pwrite[1];
  assign if1.in_pprot   = 3'b000;
  assign if1.in_pwdata  = 32'h0;
  assign if1.in_pstrb   = 4'h0;
  assign pready[1]      = if1.in_pready;
  assign pslverr[1]     = if1.in_pslverr;
  assign prdata[1]      = if1.in_prdata;

  spi_xip_apb_bridge #(.CLK_DIV(1)) dut0 (
    .clock(clock), .reset(reset), .apb(if0.slave),
    .spi_sck(sck[0]), .spi_ss(ss[0]),
    .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_xip_apb_bridge #(.CLK_DIV(3)) dut1 (
    .clock(clock), .reset(reset), .apb(if1.slave),
    .spi_sck(sck[1]), .spi_ss(ss[1]),
    .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int DIVV = (g == 0) ? 1 : 3;
    int   run = 0;
    logic prev = 1'b0;
    logic after_fall = 1'b0;

    // rise k (0-based) in a frame: k>=32 samples stream bit 63-k
    assign miso[g] = (fcnt[g][6:5] == 2'b01) ?
                     rxw[g][~fcnt[g][4:0]] : 1'b0;

    always @(posedge sck[g] or negedge ss[g][0]) begin
      if (sck[g]) begin
        if (fcnt[g] < 7'd32)
          mosi_cap[g] <= {mosi_cap[g][30:0], mosi[g]};
        fcnt[g] <= fcnt[g] + 7'd1;
        if (!ss[g][0]) rises_lo[g] <= rises_lo[g] + 1;
        else           rises_hi[g] <= rises_hi[g] + 1;
      end else begin
        fcnt[g] <= 7'd0;
      end
    end

    always @(negedge clock) begin
      if (!reset) begin
        run = 0;
        prev = 1'b0;
        after_fall = 1'b0;
      end else begin
        if (sck[g] !== prev) begin
          if (prev && run != DIVV) bad_phase[g]++;
          if (!prev && after_fall && run != DIVV) bad_phase[g]++;
          after_fall = prev;
          run = 1;
        end else begin
          run++;
        end
        if (ss[g][0]) after_fall = 1'b0;
        prev = sck[g];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int d, input logic [31:0] addr,
                      input logic wr, input logic [31:0] rx,
                      input string tag,
                      output int lat, output logic [31:0] rd,
                      output logic er, output logic [31:0] fr,
                      output int nlo, output int nhi);
    int lo0;
    int hi0;
    logic got;
    lo0 = rises_lo[d];
    hi0 = rises_hi[d];
    rxw[d] = rx;
    got = 1'b0;
    lat = -1;
    rd = 'x;
    er = 1'bx;
    @(negedge clock);
    paddr[d] = addr;
    pwrite[d] = wr;
    psel[d] = 1'b1;
    penable[d] = 1'b0;
    @(negedge clock);
    penable[d] = 1'b1;
    @(posedge clock);
    #1;
    // scramble the bus after acceptance; must not affect the transfer
    paddr[d] = ~addr;
    pwrite[d] = ~wr;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clock);
      if (pready[d]) begin
        got = 1'b1;
        lat = i;
        rd = prdata[d];
        er = pslverr[d];
      end
    end
    psel[d] = 1'b0;
    penable[d] = 1'b0;
    pwrite[d] = 1'b0;
    @(negedge clock);
    chk({tag, "_pready_1cyc"}, {31'd0, pready[d]}, 32'd0);
    fr = mosi_cap[d];
    nlo = rises_lo[d] - lo0;
    nhi = rises_hi[d] - hi0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic [31:0] fr;
  int          nlo;
  int          nhi;
  int          n;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      paddr[i] = '0;
      psel[i] = 1'b0;
      penable[i] = 1'b0;
      pwrite[i] = 1'b0;
      rxw[i] = '0;
    end
    repeat (3) @(negedge clock);
    chk("rst_pready", {31'd0, pready[0]}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    chk("rst_prdata", prdata[0], 32'd0);
    chk("rst_ss", {24'd0, ss[0]}, 32'hFF);
    chk("rst_sck", {31'd0, sck[0]}, 32'd0);
    chk("rst_mosi", {31'd0, mosi[0]}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    xfer(0, 32'h30000010, 1'b0, 32'h11223344, "rd1",
         lat, rd, er, fr, nlo, nhi);
    chk("rd1_lat", lat, 32'd129);
    chk("rd1_data", rd, 32'h44332211);
    chk("rd1_err", {31'd0, er}, 32'd0);
    chk("rd1_frame", fr, 32'h03000010);
    chk("rd1_sck_ss_lo", nlo, 32'd64);
    chk("rd1_sck_ss_hi", nhi, 32'd0);
    chk("rd1_hold", prdata[0], 32'h44332211);
    chk("rd1_mosi_idle", {31'd0, mosi[0]}, 32'd0);

    xfer(0, 32'h30000000, 1'b1, 32'h0, "wr",
         lat, rd, er, fr, nlo, nhi);
    chk("wr_lat", lat, 32'd0);
    chk("wr_err", {31'd0, er}, 32'd1);
    chk("wr_sck", nlo + nhi, 32'd0);
    chk("wr_ss", {24'd0, ss[0]}, 32'hFF);

    xfer(0, 32'h40000000, 1'b0, 32'h0, "oor",
         lat, rd, er, fr, nlo, nhi);
    chk("oor_lat", lat, 32'd0);
    chk("oor_err", {31'd0, er}, 32'd1);
    chk("oor_sck", nlo + nhi, 32'd0);

    xfer(0, 32'h2FFFFFFC, 1'b0, 32'h0, "below",
         lat, rd, er, fr, nlo, nhi);
    chk("below_err", {31'd0, er}, 32'd1);
    chk("below_sck", nlo + nhi, 32'd0);

    xfer(0, 32'h31000000, 1'b0, 32'h0, "above",
         lat, rd, er, fr, nlo, nhi);
    chk("above_err", {31'd0, er}, 32'd1);
    chk("above_sck", nlo + nhi, 32'd0);
    chk("err_hold", prdata[0], 32'h44332211);

    xfer(1, 32'h30FFFFFC, 1'b0, 32'hA55AC33C, "div3",
         lat, rd, er, fr, nlo, nhi);
    chk("div3_lat", lat, 32'd385);
    chk("div3_data", rd, 32'h3CC35AA5);
    chk("div3_err", {31'd0, er}, 32'd0);
    chk("div3_frame", fr, 32'h03FFFFFC);
    chk("div3_sck_ss_lo", nlo, 32'd64);
    chk("div3_phase", bad_phase[1], 32'd0);

    xfer(0, 32'h30000124, 1'b0, 32'hDEADBEEF, "scr",
         lat, rd, er, fr, nlo, nhi);
    chk("scr_lat", lat, 32'd129);
    chk("scr_data", rd, 32'hEFBEADDE);
    chk("scr_frame", fr, 32'h03000124);

    rxw[0] = 32'h0;
    @(negedge clock);
    paddr[0] = 32'h30000200;
    psel[0] = 1'b1;
    @(negedge clock);
    penable[0] = 1'b1;
    @(posedge clock);
    #1;
    psel[0] = 1'b0;
    penable[0] = 1'b0;
    n = 0;
    while (fcnt[0] != 7'd10 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reach_bit10", {25'd0, fcnt[0]}, 32'd10);
    reset = 1'b0;
    #1;
    chk("abort_ss", {24'd0, ss[0]}, 32'hFF);
    chk("abort_sck", {31'd0, sck[0]}, 32'd0);
    chk("abort_mosi", {31'd0, mosi[0]}, 32'd0);
    chk("abort_prdata", prdata[0], 32'd0);
    chk("abort_prdata1", prdata[1], 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    xfer(0, 32'h30000010, 1'b0, 32'h11223344, "post",
         lat, rd, er, fr, nlo, nhi);
    chk("post_lat", lat, 32'd129);
    chk("post_data", rd, 32'h44332211);
    chk("post_frame", fr, 32'h03000010);
    chk("post_sck_ss_lo", nlo, 32'd64);

    xfer(0, 32'h30000010, 1'b0, 32'h99999999, "again",
         lat, rd, er, fr, nlo, nhi);
`ifdef SPI_XIP_LINE_BUF_EN
    chk("again_lat", lat, 32'd0);
    chk("again_data", rd, 32'h44332211);
    chk("again_sck", nlo + nhi, 32'd0);
`else
    chk("again_lat", lat, 32'd129);
    chk("again_data", rd, 32'h99999999);
    chk("again_sck", nlo, 32'd64);
`endif
    chk("again_err", {31'd0, er}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_xip_apb_bridge.md
SPI_XIP_APB_BRIDGE -- requirements
Module: spi_xip_apb_bridge

Interface
REQ-001 Parameter FLASH_BASE, default 32'h30000000: first byte address of the flash XIP window.
REQ-002 Parameter FLASH_SIZE_LOG2, default 24: window size is 2^FLASH_SIZE_LOG2 bytes, range 12..24.
REQ-003 Parameter SS_NUM, default 8: width of spi_ss.
REQ-004 Parameter SS_IDX, default 0: spi_ss bit used for the flash, range 0..SS_NUM-1.
REQ-005 Parameter CLK_DIV, default 1: clock cycles per SCK half-period, range 1..255.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 in_paddr  in  32  APB address.
REQ-009 in_psel, in_penable, in_pwrite  in  1 each  APB control.
REQ-010 in_pprot  in  3, in_pwdata  in  32, in_pstrb  in  4  accepted and ignored.
REQ-011 in_pready  out  1  APB ready; in_prdata  out  32  read data; in_pslverr  out  1  APB error.
REQ-012 spi_sck  out  1; spi_ss  out  SS_NUM, active-low; spi_mosi  out  1; spi_miso  in  1.

Function
REQ-013 States SHALL be IDLE, SHIFT_OUT, SHIFT_IN, RESP.
REQ-014 An access is accepted in IDLE when in_psel and in_penable are both 1.
- Write, or address outside [FLASH_BASE, FLASH_BASE+2^FLASH_SIZE_LOG2): go to RESP with in_pslverr=1 and no SPI activity.
- Otherwise go to SHIFT_OUT.
REQ-015 SHIFT_OUT SHALL shift the 32-bit frame {8'h03, 24-bit word address}, MSB first, where the word address is in_paddr[FLASH_SIZE_LOG2-1:2] zero-extended to 22 bits, followed by 2'b00.
REQ-016 SPI mode 0:
- spi_sck idles low.
- spi_mosi changes only while spi_sck is low.
- spi_miso is sampled on the clock where spi_sck rises.
REQ-017 Each SCK half-period SHALL last exactly CLK_DIV clocks; a transfer is 64 SCK periods (32 out, then 32 in).
REQ-018 spi_ss[SS_IDX] SHALL be 0 from the first SHIFT_OUT cycle through the last SHIFT_IN cycle, and 1 otherwise.
- All other spi_ss bits are 1 at all times.
REQ-019 SHIFT_IN SHALL capture 4 bytes b0..b3 in arrival order (each MSB first) and present in_prdata = {b3,b2,b1,b0}.
REQ-020 RESP SHALL assert in_pready for exactly one cycle and then return to IDLE.
- in_prdata is valid in that cycle; in_pslverr is valid in that cycle only.
REQ-021 Latency: for a read accepted at clock edge T, in_pready SHALL be 1 in the cycle after edge T+1+128*CLK_DIV.
- With CLK_DIV=1, in_pready is high during cycle T+130.
REQ-022 An error response SHALL complete with in_pready high in the cycle after the accepting edge.
REQ-023 Outside RESP, in_pready=0, in_pslverr=0 and in_prdata holds its last value.
REQ-024 APB address and control are captured at acceptance; changes on the APB inputs before RESP SHALL NOT alter the transfer.
REQ-025 spi_mosi SHALL be 0 outside SHIFT_OUT.

Reset
REQ-026 Asserting reset SHALL, with no clock edge required:
- force state IDLE;
- set spi_sck=0, spi_ss all 1, spi_mosi=0;
- set in_pready=0, in_pslverr=0, in_prdata=0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer; after reset is released, the next accepted access starts a fresh frame.

Configuration
REQ-028 Macro SPI_XIP_LINE_BUF_EN SHALL control a one-word read buffer.
- Defined: the buffer holds a valid bit, the 22-bit word address and the data of the last successful read.
- Defined, buffer hit on a read accepted in IDLE: go directly to RESP with the buffered data, no SPI activity, in_pready high the cycle after acceptance.
- Defined, miss: perform the normal transfer and update the buffer in RESP.
- Defined: the valid bit is cleared by reset.
- Undefined: every read performs the full SPI transfer, and no buffer storage exists.

Verification
REQ-029 CLK_DIV=1, read 0x30000010 with miso supplying bytes 0x11,0x22,0x33,0x44:
- MOSI frame = 0x03000010;
- in_prdata=0x44332211, in_pready at T+130;
- 64 SCK rising edges while spi_ss[0]=0.
REQ-030 Write to 0x30000000: in_pready=1 and in_pslverr=1 one cycle after acceptance; spi_ss stays all 1; no SCK edges.
REQ-031 Read 0x40000000: in_pslverr=1; no SPI activity.
REQ-032 CLK_DIV=3, read 0x30FFFFFC:
- frame = 0x03FFFFFC;
- SCK high and low phases each 3 clocks;
- in_pready at T+386.
REQ-033 Reset pulled low at SHIFT_OUT bit 10:
- spi_ss returns to all 1 and spi_sck to 0 immediately;
- the next read completes correctly.
REQ-034 With SPI_XIP_LINE_BUF_EN defined, read 0x30000010 twice: the second read returns the same data one cycle after acceptance with no SCK edges.
